fetch_queue: RTL

//  Parametrised instruction-fetch unit with prefetch buffer; replaces the free-running PC increment in the CPU top.

---
 rtl/fetch_queue.sv | 117 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch unit: drives imem over req/ack, buffers {pc, word} in a DEPTH-entry FIFO,
// and presents the head to decode with valid/ready. Supports redirect flushes and a halt word.
module fetch_queue #(
    parameter int unsigned ADDR_W                  = 16,
    parameter int unsigned INSTR_W                 = 16,
    parameter int unsigned DEPTH                   = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC         = '0,
    parameter logic [INSTR_W-1:0] HALT_WORD        = '1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    output logic                         o_imem_req,
    output logic [ADDR_W-1:0]            o_imem_addr,
    input  logic                         i_imem_ack,
    input  logic [INSTR_W-1:0]           i_imem_rdata,
    output logic                         o_instr_valid,
    output logic [INSTR_W-1:0]           o_instr,
    output logic [ADDR_W-1:0]            o_instr_pc,
    input  logic                         i_instr_ready,
    input  logic                         i_redirect,
    input  logic [ADDR_W-1:0]            i_redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_halted
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic               r_fetch_stop;
    logic               r_halted;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];

    logic w_full;
    logic w_req;
    logic w_push;
    logic w_valid;
    logic w_pop;
    logic w_flush;
    logic w_pop_halt;
    logic w_rdata_halt;

    // Request depends on registered state only, so decode's ready never reaches imem.
    assign w_full       = (r_level == LVL_W'(DEPTH));
    assign w_req        = !i_rst && !r_halted && !r_fetch_stop && !w_full;
    assign w_push       = w_req && i_imem_ack;
    assign w_valid      = (r_level != '0) && !r_halted;
    assign w_pop        = w_valid && i_instr_ready;
    assign w_flush      = i_redirect && !r_halted;
    assign w_pop_halt   = w_pop && (r_instr_mem[r_rd_ptr] == HALT_WORD);
    assign w_rdata_halt = (i_imem_rdata == HALT_WORD);

    assign o_imem_req    = w_req;
    assign o_imem_addr   = r_fetch_pc;
    assign o_instr_valid = w_valid;
    assign o_instr       = r_instr_mem[r_rd_ptr];
    assign o_instr_pc    = r_pc_mem[r_rd_ptr];
    assign o_level       = r_level;
    assign o_halted      = r_halted;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc   <= RESET_PC;
            r_fetch_stop <= 1'b0;
            r_halted     <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
        end else begin
            // A halt word popped alongside a redirect still counts as consumed.
            if (w_pop_halt) begin
                r_halted <= 1'b1;
            end
            if (w_flush) begin
                r_fetch_pc   <= i_redirect_pc;
                r_fetch_stop <= 1'b0;
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_level      <= '0;
            end else begin
                if (w_push) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                    r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
                    if (w_rdata_halt) begin
                        r_fetch_stop <= 1'b1;
                    end
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LVL_W'(1);
                    2'b01:   r_level <= r_level - LVL_W'(1);
                    default: r_level <= r_level;
                endcase
            end
        end
    end

    // Storage is cleared on reset so the head outputs read zero until the first push.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (w_push && !w_flush) begin
            r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
            r_instr_mem[r_wr_ptr] <= i_imem_rdata;
        end
    end

endmodule
